// File: rtl/pulse_gen.sv
// pulse_gen: programmable single-shot pulse generator.
//
// An accepted trigger starts a delay of `delay` cycles, followed by an active
// pulse of max(`width`,1) cycles on `dout`. Configuration is captured when the
// trigger is accepted, so later changes only affect the next run.
//
// Parameters:
//   CNT_W      - width of the delay/width counters and configuration inputs
//   IDLE_LEVEL - level of dout when no pulse is active (active level is inverted)
//
// Ports:
//   clk     - clock, all logic on rising edge
//   rst_n   - synchronous active-low reset
//   trig    - start strobe
//   delay   - cycles from trigger acceptance to pulse start
//   width   - active pulse length in cycles (0 behaves as 1)
//   dout    - generated pulse, registered
//   busy    - high during the delay and pulse phases
//   done    - one-cycle strobe in the cycle dout returns to idle
//   overrun - one-cycle strobe after a trigger rejected while busy
module pulse_gen #(
   parameter int unsigned CNT_W      = 16,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] width,
   output logic             dout,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] One = CNT_W'(1);

   typedef enum logic [1:0] {
      StIdle,
      StDelay,
      StPulse
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] delay_q, delay_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             overrun_q, overrun_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + One;
      delay_d = delay_q;
      width_d = width_q;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (trig) begin
               delay_d = delay;
               width_d = (width == '0) ? One : width;
               state_d = (delay == '0) ? StPulse : StDelay;
            end
         end
         StDelay: begin
            // delay_q is nonzero here, so the subtraction cannot underflow
            if (cnt_q == delay_q - One) begin
               state_d = StPulse;
               cnt_d   = '0;
            end
         end
         StPulse: begin
            if (cnt_q == width_q - One) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered from the next state so they line up with it
      busy_d    = (state_d != StIdle);
      dout_d    = (state_d == StPulse) ? ~IDLE_LEVEL : IDLE_LEVEL;
      done_d    = (state_q == StPulse) && (state_d == StIdle);
      overrun_d = trig && (state_q != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         delay_q   <= '0;
         width_q   <= '0;
         dout_q    <= IDLE_LEVEL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         delay_q   <= delay_d;
         width_q   <= width_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign dout    = dout_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: self-checking bench for pulse_gen.
//
// Two instances share clk, rst_n and trig: inst 0 with CNT_W=16/IDLE_LEVEL=0,
// inst 1 with CNT_W=4/IDLE_LEVEL=1. Each stimulus cycle the reference model
// computes per-run time windows with plain arithmetic and pushes the expected
// outputs for the following cycle into a scoreboard queue; a monitor pops and
// compares on the falling edge.
module tb_pulse_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        trig;
   logic [15:0] delay_a, width_a;
   logic [3:0]  delay_b, width_b;
   logic        dout_a, busy_a, done_a, overrun_a;
   logic        dout_b, busy_b, done_b, overrun_b;

   always #5 clk = ~clk;

   pulse_gen #(
      .CNT_W      (16),
      .IDLE_LEVEL (1'b0)
   ) dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .trig    (trig),
      .delay   (delay_a),
      .width   (width_a),
      .dout    (dout_a),
      .busy    (busy_a),
      .done    (done_a),
      .overrun (overrun_a)
   );

   pulse_gen #(
      .CNT_W      (4),
      .IDLE_LEVEL (1'b1)
   ) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .trig    (trig),
      .delay   (delay_b),
      .width   (width_b),
      .dout    (dout_b),
      .busy    (busy_b),
      .done    (done_b),
      .overrun (overrun_b)
   );

   typedef struct {
      int   cyc;
      int   inst;
      logic dout;
      logic busy;
      logic done;
      logic overrun;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Reference model: the most recent accepted run per instance
   bit m_run[2];
   int m_n[2];
   int m_d[2];
   int m_w[2];

   function automatic bit m_busy(int i, int t);
      return m_run[i] && (t >= m_n[i] + 1) && (t <= m_n[i] + m_d[i] + m_w[i]);
   endfunction

   function automatic bit m_active(int i, int t);
      return m_run[i] && (t >= m_n[i] + 1 + m_d[i]) && (t <= m_n[i] + m_d[i] + m_w[i]);
   endfunction

   task automatic chk(string name, int inst, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d cyc=%0d got=%b want=%b", name, inst, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs, predict the next cycle, then advance
   task automatic step(bit rst, bit tg, int da, int wa, int db, int wb);
      int   dcfg[2];
      int   wcfg[2];
      bit   ov;
      exp_t e;
      rst_n   = !rst;
      trig    = tg;
      delay_a = 16'(da);
      width_a = 16'(wa);
      delay_b = 4'(db);
      width_b = 4'(wb);
      dcfg[0] = int'(delay_a);
      wcfg[0] = int'(width_a);
      dcfg[1] = int'(delay_b);
      wcfg[1] = int'(width_b);
      for (int i = 0; i < 2; i++) begin
         ov = 1'b0;
         if (rst) begin
            m_run[i] = 1'b0;
         end else begin
            ov = tg && m_busy(i, cyc);
            if (tg && !m_busy(i, cyc)) begin
               m_run[i] = 1'b1;
               m_n[i]   = cyc;
               m_d[i]   = dcfg[i];
               m_w[i]   = (wcfg[i] == 0) ? 1 : wcfg[i];
            end
         end
         e.cyc     = cyc + 1;
         e.inst    = i;
         e.busy    = m_busy(i, cyc + 1);
         e.dout    = m_active(i, cyc + 1) ^ (i == 1);
         e.done    = m_run[i] && (cyc + 1 == m_n[i] + m_d[i] + m_w[i] + 1);
         e.overrun = ov;
         sb_q.push_back(e);
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(int n, int d, int w);
      repeat (n) step(1'b0, 1'b0, d, w, d, w);
   endtask

   // Monitor: compare every expectation whose cycle has arrived
   always @(negedge clk) begin
      exp_t e;
      logic ad, ab, adn, aov;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         if (e.inst == 0) {ad, ab, adn, aov} = {dout_a, busy_a, done_a, overrun_a};
         else             {ad, ab, adn, aov} = {dout_b, busy_b, done_b, overrun_b};
         chk("dout",    e.inst, ad,  e.dout);
         chk("busy",    e.inst, ab,  e.busy);
         chk("done",    e.inst, adn, e.done);
         chk("overrun", e.inst, aov, e.overrun);
      end
   end

   initial begin
      m_run = '{1'b0, 1'b0};
      m_n   = '{0, 0};
      m_d   = '{0, 0};
      m_w   = '{0, 0};

      // Reset held with trig high, then no run while trig stays low
      repeat (3) step(1'b1, 1'b1, 2, 2, 2, 2);
      idle(3, 5, 5);

      // delay=0 width=1, then delay=3 width=5
      step(1'b0, 1'b1, 0, 1, 0, 1);
      idle(4, 0, 1);
      step(1'b0, 1'b1, 3, 5, 3, 5);
      idle(10, 3, 5);

      // width=0 behaves as 1
      step(1'b0, 1'b1, 2, 0, 2, 0);
      idle(5, 2, 0);

      // Rejected trigger at N+2 of a delay=3 width=5 run
      step(1'b0, 1'b1, 3, 5, 3, 5);
      idle(1, 3, 5);
      step(1'b0, 1'b1, 7, 7, 7, 7);
      idle(8, 3, 5);

      // Back-to-back with config change; second trig in the done cycle
      step(1'b0, 1'b1, 1, 2, 1, 2);
      idle(3, 0, 4);
      step(1'b0, 1'b1, 0, 4, 0, 4);
      idle(6, 0, 4);

      // Reset during the pulse phase, then a normal run
      step(1'b0, 1'b1, 2, 6, 2, 6);
      idle(4, 2, 6);
      step(1'b1, 1'b0, 2, 6, 2, 6);
      idle(2, 2, 6);
      step(1'b0, 1'b1, 1, 2, 1, 2);
      idle(5, 1, 2);

      // Maximum 4-bit delay and width: no early wrap on the narrow instance
      step(1'b0, 1'b1, 15, 15, 15, 15);
      idle(35, 15, 15);

      // Held-high trigger: overrun every busy cycle, re-accept in done cycle
      repeat (10) step(1'b0, 1'b1, 2, 3, 2, 3);
      idle(8, 2, 3);

      // Randomized traffic with configuration churn and occasional reset
      repeat (3000) begin
         int d, w;
         d = (($urandom_range(0, 15) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 5));
         w = (($urandom_range(0, 15) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 5));
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, d, w,
              $urandom_range(0, 15), $urandom_range(0, 15));
      end
      idle(40, 0, 1);

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable single-shot pulse generator in the general HDL library, the counterpart of the edge detectors: where `edgeneg` reduces a level transition to a one-cycle strobe, `pulse_gen` turns a one-cycle strobe back into a timed level pulse with defined rising and falling edges. A trigger starts a run-time-programmable delay, followed by an active pulse of programmable width. Busy, done and overrun flags support use in handshake and timing-generation logic.

## Interface
- `CNT_W`, 16, width of the delay and width counters and their configuration inputs.
- `IDLE_LEVEL`, 0, level of `dout` when no pulse is active. The active level is `~IDLE_LEVEL`. A value of 1 gives an active-low pulse, whose leading edge is a falling edge.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `trig` input 1: start strobe, sampled every cycle.
- `delay` input CNT_W: cycles from trigger acceptance to pulse start, unsigned. Captured on an accepted trigger.
- `width` input CNT_W: active pulse length in cycles, unsigned. Captured on an accepted trigger. A value of 0 is treated as 1.
- `dout` output 1: generated pulse, registered.
- `busy` output 1: high while a run is in progress (DELAY or PULSE state).
- `done` output 1: one-cycle strobe in the cycle `dout` returns to idle.
- `overrun` output 1: one-cycle strobe after a trigger that was rejected because the block was busy.

## Operation
- The block has three states: IDLE, DELAY and PULSE.
- **IDLE**
  - `trig`=1 accepts the trigger.
  - `delay` and `width` are latched into internal registers.
  - Next state is DELAY if the latched delay is nonzero, otherwise PULSE.
- **DELAY**
  - The counter counts from 0 up to latched delay−1.
  - When the count equals delay−1, next state is PULSE.
- **PULSE**
  - `dout` is at the active level for exactly max(width,1) cycles.
  - Then next state is IDLE and `done` is pulsed.
- **Triggers while busy**
  - `trig` in DELAY or PULSE is ignored; the run is unaffected and `overrun`=1 on the next cycle.
  - A held-high `trig` produces an `overrun` strobe every busy cycle.
- **Trigger in the done cycle**
  - The FSM is in IDLE during the `done` cycle, so a `trig` in that cycle is accepted.
  - This allows back-to-back pulses separated by one idle cycle.
- **Configuration changes**
  - Changes to `delay` or `width` during a run have no effect on that run; they apply only to the next accepted trigger.
- **Counter width**
  - Counters are CNT_W bits and compare for equality.
  - The maximum values 2^CNT_W−1 are legal and must not wrap early or overflow.
- **Reset**
  - `rst_n`=0 forces IDLE and clears the counters.
  - Outputs: `dout`=IDLE_LEVEL, `busy`=0, `done`=0, `overrun`=0.
  - Reset overrides a simultaneous `trig`.
  - Reset mid-run aborts the run with no `done` strobe.

## Timing
Let N be the cycle in which `trig` is sampled high while idle, with d = latched delay and w = max(latched width,1).
- `busy` is high in cycles N+1 through N+d+w.
- `dout` is active in cycles N+1+d through N+d+w.
- With d=0, `dout` goes active at N+1, one cycle of latency.
- `done` and the return of `dout` to idle both occur in cycle N+d+w+1, when `busy`=0.
- The earliest re-accepted trigger is at N+d+w+1, giving the next pulse start at N+d+w+2+d'.
- `overrun` appears one cycle after the rejected `trig`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold `rst_n`=0 for 3 cycles with `trig`=1 and IDLE_LEVEL=0 -> `dout`=0, `busy`=0, `done`=0, `overrun`=0 throughout, and no run starts after reset releases if `trig` is low.
- **Basic timing:**
  - delay=0, width=1, trig at N -> `dout`=1 only at N+1, `done` at N+2, `busy` only at N+1.
  - delay=3, width=5 -> `dout`=1 in N+4..N+8, `done` at N+9.
- **Width zero and rejected trigger:** width=0 behaves as width=1. A trig at N+2 during a delay=3, width=5 run -> `overrun`=1 at N+3, and the original pulse timing is unchanged.
- **Back-to-back with config change:**
  - Run 1: delay=1, width=2, trig at N.
  - Change inputs to delay=0, width=4 at N+1.
  - Trig again at the `done` cycle N+4.
  - Expected: the first pulse is at N+2..N+3, the second at N+5..N+8, with one idle cycle at N+4.
- **Reset mid-run:**
  - Assert `rst_n`=0 during PULSE.
  - Expected: `dout` is idle the next cycle, `busy`=0, and there is no `done` strobe.
  - A new trigger after release produces a normal pulse.
- **Boundaries with inverted idle level:**
  - Configuration: CNT_W=4, IDLE_LEVEL=1, delay=15, width=15.
  - Expected: `dout`=0 for exactly 15 cycles starting at N+16, `done` at N+31, and no early wrap.
